// File: rtl/ewrapper_rx_frame_align_if.sv
// Bus between the elink 1:8 deserializer and the receive protocol logic.
// The deserializer side is the master. The alignment stage is the slave.
interface ewrapper_rx_frame_align_if;
    logic [71:0] DATA_IN;
    logic [63:0] DATA_OUT;
    logic        DATA_VALID;
    logic        FRAME_START;
    logic [2:0]  OFFSET;
    logic        ALIGN_ERR;
    logic [7:0]  ERR_COUNT;
    logic [15:0] FRAME_COUNT;

    modport slave (
        input  DATA_IN,
        output DATA_OUT, DATA_VALID, FRAME_START, OFFSET, ALIGN_ERR, ERR_COUNT, FRAME_COUNT
    );

    modport master (
        output DATA_IN,
        input  DATA_OUT, DATA_VALID, FRAME_START, OFFSET, ALIGN_ERR, ERR_COUNT, FRAME_COUNT
    );
endinterface

// File: rtl/ewrapper_rx_frame_align.sv
// elink receive byte alignment. This block runs in the divided receive clock domain.
// It finds the frame start bit inside the frame lane (lane 8). It then realigns all
// lanes across 72-bit word boundaries and emits 64-bit beats with valid/start/error.
// Optional statistics counters are enabled by the macro EWRAPPER_RX_ALIGN_STATS_EN.
// When that macro is not defined, ERR_COUNT and FRAME_COUNT are tied to 0.
//
// state  | meaning
// IDLE   | waiting for a frame start pattern (8'hFF >> k) in the raw frame byte
// ACTIVE | frame open at latched offset; emitting a beat per all-ones frame window
// RESYNC | after an error; waiting for an all-zero raw frame byte
module ewrapper_rx_frame_align #(
    parameter int unsigned MAX_FRAME_BEATS = 0
) (
    input  logic                           CLK_DIV,
    input  logic                           RESET_N,
    ewrapper_rx_frame_align_if.slave       rx
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESYNC} state_t;

    localparam logic [7:0] MAX_BEATS = 8'(MAX_FRAME_BEATS);

    state_t      state_q;
    logic [71:0] in_q;
    logic [71:0] prev_q;
    logic [2:0]  offset_q;
    logic [63:0] data_q;
    logic        valid_q;
    logic        start_q;
    logic        err_q;
    logic        first_q;
    logic [7:0]  beats_q;

    logic [7:0]  raw_f;
    logic [7:0]  fw;
    logic [63:0] w_data;
    logic        start_hit;
    logic [2:0]  start_k;
    logic        wd_hit;
    logic        eval_start;
    logic        beat_d;
    logic        launch_d;
    logic        err_d;

    // Eight bits from the {older, newer} byte pair, starting k bits into the older byte
    function automatic logic [7:0] win8(input logic [7:0] hi, input logic [7:0] lo,
                                        input logic [2:0] k);
        logic [15:0] s;
        s = {hi, lo} << k;
        return s[15:8];
    endfunction

    // Two-word input pipeline, so a byte can be assembled across a word boundary
    always_ff @(posedge CLK_DIV or negedge RESET_N) begin
        if (!RESET_N) begin
            in_q   <= '0;
            prev_q <= '0;
        end else begin
            in_q   <= rx.DATA_IN;
            prev_q <= in_q;
        end
    end

    // Shifted windows for each lane, start-pattern search, and the decisions for this cycle
    always_comb begin
        raw_f     = in_q[71:64];
        fw        = win8(prev_q[71:64], in_q[71:64], offset_q);
        w_data    = '0;
        for (int l = 0; l < 8; l++) begin
            w_data[8*l +: 8] = win8(prev_q[8*l +: 8], in_q[8*l +: 8], offset_q);
        end
        start_hit = 1'b0;
        start_k   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (raw_f == (8'hFF >> k)) begin
                start_hit = 1'b1;
                start_k   = 3'(k);
            end
        end
        wd_hit     = (MAX_FRAME_BEATS != 0) && (beats_q == MAX_BEATS);
        // The end of a frame also re-runs start detection, so back-to-back frames need no IDLE gap
        eval_start = (state_q == IDLE) || ((state_q == ACTIVE) && (fw == 8'h00));
        beat_d     = (state_q == ACTIVE) && (fw == 8'hFF) && !wd_hit;
        launch_d   = eval_start && start_hit;
        err_d      = (eval_start && (raw_f != 8'h00) && !start_hit)
                   || ((state_q == ACTIVE) && (fw == 8'hFF) && wd_hit)
                   || ((state_q == ACTIVE) && (fw != 8'hFF) && (fw != 8'h00));
    end

    // Alignment FSM with registered beat, start, error and offset outputs
    always_ff @(posedge CLK_DIV or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            offset_q <= 3'd0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            first_q  <= 1'b0;
            beats_q  <= 8'd0;
        end else begin
            valid_q <= beat_d;
            start_q <= beat_d && first_q;
            err_q   <= err_d;
            if (beat_d) begin
                data_q  <= w_data;
                first_q <= 1'b0;
                beats_q <= beats_q + 8'd1;
            end
            if (launch_d) begin
                offset_q <= start_k;
                first_q  <= 1'b1;
                beats_q  <= 8'd0;
            end
            case (state_q)
                IDLE: begin
                    if (launch_d)   state_q <= ACTIVE;
                    else if (err_d) state_q <= RESYNC;
                end
                ACTIVE: begin
                    if (launch_d)           state_q <= ACTIVE;
                    else if (err_d)         state_q <= RESYNC;
                    else if (fw == 8'h00)   state_q <= IDLE;
                end
                RESYNC: begin
                    if (raw_f == 8'h00) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx.DATA_OUT    = data_q;
    assign rx.DATA_VALID  = valid_q;
    assign rx.FRAME_START = start_q;
    assign rx.OFFSET      = offset_q;
    assign rx.ALIGN_ERR   = err_q;

`ifdef EWRAPPER_RX_ALIGN_STATS_EN
    logic [7:0]  err_cnt_q;
    logic [15:0] frame_cnt_q;

    // Saturating error count and wrapping frame count. Both update on the same edge as the event.
    always_ff @(posedge CLK_DIV or negedge RESET_N) begin
        if (!RESET_N) begin
            err_cnt_q   <= 8'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            if (err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
            if (launch_d) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign rx.ERR_COUNT   = err_cnt_q;
    assign rx.FRAME_COUNT = frame_cnt_q;
`else
    assign rx.ERR_COUNT   = 8'd0;
    assign rx.FRAME_COUNT = 16'd0;
`endif

endmodule
